// File: rtl/regbus_pkg.sv
// Purpose: shared encodings and elaboration helpers for the register-bus arbiter.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package regbus_pkg;

  // Arbiter FSM encoding; the value 2'd3 is unused and decodes back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

  // Legal parameter ranges.
  localparam int unsigned MinClients = 2;
  localparam int unsigned MaxClients = 16;
  localparam int unsigned MinHold    = 1;
  localparam int unsigned MaxHold    = 255;
  localparam int unsigned MinTurn    = 1;
  localparam int unsigned MaxTurn    = 4;

  // Ceiling log2 that never returns 0, so every derived vector is at least one bit wide.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < v) begin
        r = i + 1;
      end
    end
    return (r == 0) ? 1 : r;
  endfunction

  // A TurnCycles of 0 would let two drivers overlap on the bus, so it is rejected here.
  function automatic bit params_ok(input int unsigned n, input int unsigned h,
                                   input int unsigned t);
    return (n >= MinClients) && (n <= MaxClients) &&
           (h >= MinHold)    && (h <= MaxHold)    &&
           (t >= MinTurn)    && (t <= MaxTurn);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Purpose: round-robin winner search; the client at rr_ptr_i has top priority, then ascending mod N.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a winner is taken.
module rr_priority_picker #(
  parameter int unsigned N    = 4,
  parameter int unsigned PtrW = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [PtrW-1:0] rr_ptr_i,
  output logic            any_req_o,
  output logic [PtrW-1:0] winner_o
);

  localparam int unsigned SW = PtrW + 1;
  localparam logic [SW-1:0] NumClients = SW'(N);

  logic [N-1:0]  rotated;
  logic [SW-1:0] src;
  logic [SW-1:0] offset;
  logic [SW-1:0] sum;
  logic          found;

  // Rotate the request vector so that bit 0 is the client at rr_ptr_i.
  // The wrap is an explicit subtract because N need not be a power of two.
  always_comb begin
    rotated = '0;
    src     = '0;
    for (int i = 0; i < N; i++) begin
      src = SW'(i) + {1'b0, rr_ptr_i};
      if (src >= NumClients) begin
        src = src - NumClients;
      end
      rotated[i] = req_i[src[PtrW-1:0]];
    end
  end

  // Take the lowest set bit of the rotated vector, then undo the rotation.
  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && rotated[i]) begin
        found  = 1'b1;
        offset = SW'(i);
      end
    end
    sum = offset + {1'b0, rr_ptr_i};
    if (sum >= NumClients) begin
      sum = sum - NumClients;
    end
    winner_o  = sum[PtrW-1:0];
    any_req_o = found;
  end

endmodule

// File: rtl/regbus_rr_arbiter.sv
// Purpose: round-robin owner of a shared tri-state register bus, driving active-low cs per register.
// Latency: Req to Grant/Cs takes one Tick edge; owners are separated by TurnCycles all-high-Z Ticks.
// Backpressure: Tick=0 freezes all state; an owner keeps the bus until Done, Req drop or HoldMax Ticks.
module regbus_rr_arbiter
  import regbus_pkg::*;
#(
  parameter  int unsigned NrOfClients = 4,
  parameter  int unsigned HoldMax     = 8,
  parameter  int unsigned TurnCycles  = 1,
  localparam int unsigned OwnerW      = clog2(NrOfClients)
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic                   Tick,
  input  logic [NrOfClients-1:0] Req,
  input  logic [NrOfClients-1:0] Done,
  output logic [NrOfClients-1:0] Grant,
  output logic [NrOfClients-1:0] Cs,
  output logic [OwnerW-1:0]      Owner,
  output logic                   BusBusy
);

  localparam int unsigned HoldW    = clog2(HoldMax + 1);
  localparam int unsigned TurnW    = clog2(TurnCycles + 1);
  localparam bit          ParamsOk = params_ok(NrOfClients, HoldMax, TurnCycles);

  localparam logic [OwnerW-1:0] LastIdx   = OwnerW'(NrOfClients - 1);
  localparam logic [HoldW-1:0]  HoldLimit = HoldW'(HoldMax);
  localparam logic [TurnW-1:0]  TurnLimit = TurnW'(TurnCycles);

  state_e                 state_q;
  logic [NrOfClients-1:0] grant_q;
  logic [NrOfClients-1:0] cs_q;
  logic [OwnerW-1:0]      owner_q;
  logic [OwnerW-1:0]      rr_ptr_q;
  logic [OwnerW-1:0]      rr_ptr_d;
  logic [HoldW-1:0]       hold_cnt_q;
  logic [HoldW-1:0]       hold_cnt_d;
  logic [TurnW-1:0]       turn_cnt_q;
  logic [TurnW-1:0]       turn_cnt_d;
  logic                   busy_q;

  logic                   any_req;
  logic [OwnerW-1:0]      winner;
  logic [NrOfClients-1:0] winner_onehot;
  logic                   release_now;
  logic                   turn_last;

  rr_priority_picker #(
    .N    (NrOfClients),
    .PtrW (OwnerW)
  ) u_picker (
    .req_i     (Req),
    .rr_ptr_i  (rr_ptr_q),
    .any_req_o (any_req),
    .winner_o  (winner)
  );

  // Next-value helpers: release decision, pointer wrap and saturating counters.
  always_comb begin
    winner_onehot = NrOfClients'(1) << winner;
    // Only the owner's Done/Req matter; a simultaneous Done and HoldMax is one release.
    release_now   = Done[owner_q] | ~Req[owner_q] | (hold_cnt_q == HoldLimit);
    rr_ptr_d      = (owner_q == LastIdx) ? '0 : owner_q + 1'b1;
    hold_cnt_d    = (hold_cnt_q == HoldLimit) ? hold_cnt_q : hold_cnt_q + 1'b1;
    turn_last     = (turn_cnt_q >= TurnLimit);
    turn_cnt_d    = turn_last ? turn_cnt_q : turn_cnt_q + 1'b1;
  end

  // Arbiter FSM with registered outputs; the async reset releases every cs immediately.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      cs_q       <= '1;
      owner_q    <= '0;
      busy_q     <= 1'b0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      turn_cnt_q <= '0;
    end else if (Tick) begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            state_q    <= ST_GRANT;
            grant_q    <= winner_onehot;
            cs_q       <= ~winner_onehot;
            owner_q    <= winner;
            busy_q     <= 1'b1;
            hold_cnt_q <= HoldW'(1);
          end
        end
        ST_GRANT: begin
          if (release_now) begin
            // Released owner drops to lowest priority by moving the pointer past it.
            state_q    <= ST_TURN;
            grant_q    <= '0;
            cs_q       <= '1;
            rr_ptr_q   <= rr_ptr_d;
            turn_cnt_q <= TurnW'(1);
          end else begin
            hold_cnt_q <= hold_cnt_d;
          end
        end
        ST_TURN: begin
          if (turn_last) begin
            // Final turnaround Tick doubles as an arbitration slot.
            if (any_req) begin
              state_q    <= ST_GRANT;
              grant_q    <= winner_onehot;
              cs_q       <= ~winner_onehot;
              owner_q    <= winner;
              hold_cnt_q <= HoldW'(1);
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            turn_cnt_q <= turn_cnt_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          cs_q    <= '1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Grant   = grant_q;
  assign Cs      = cs_q;
  assign Owner   = owner_q;
  assign BusBusy = busy_q;

  // Bus-safety invariants: never two drivers, cs always the inverse of grant, legal parameters.
  a_grant_onehot0: assert property (@(posedge Clock) disable iff (!Reset_n) $onehot0(grant_q));
  a_cs_inverse:    assert property (@(posedge Clock) disable iff (!Reset_n) cs_q == ~grant_q);
  a_params_legal:  assert property (@(posedge Clock) disable iff (!Reset_n) ParamsOk);

endmodule
